jk_counter_ctrl: RTL and testbench

Excitation controller for a bank of WIDTH JK flip-flops forming a programmable mod-MODULUS up/down counter. The block sits directly upstream of the JK flop bank: it reads the bank's Q outputs as feedback and drives each flop's J and K so that the bank steps, loads or holds on the shared clock edge. It also keeps a shadow copy of the expected count and latches a sticky fault when the bank diverges from it. On a fault it forces the bank to clear.

---
 rtl/jk_counter_ctrl.sv | 97 +++++++++
 tb/tb_jk_counter_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_counter_ctrl.sv
// Excitation controller for a JK flop bank forming a mod-MODULUS up/down counter.
// Keeps a shadow count and forces the bank clear on a divergence fault.
module jk_counter_ctrl #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             tc,
  output logic             err,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH:0]   MOD = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   lv_ext;
  logic             mismatch;
  logic             force_clr;

  assign q_ext    = {1'b0, q_fb};
  assign lv_ext   = {1'b0, load_val};
  assign mismatch = (q_fb != count);

  always_comb begin
    nxt = q_fb;
    unique case (1'b1)
      load: begin
        nxt = (lv_ext >= MOD) ? '0 : load_val;
      end
      (~load & en & up): begin
        nxt = (q_fb >= TOP) ? '0 : q_fb + 1'b1;
      end
      (~load & en & ~up): begin
        nxt = (q_fb == '0 || q_ext >= MOD) ? TOP : q_fb - 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (mismatch) state_nxt = FAULT;
      FAULT:   if (clr_err)  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (state == RUN && !mismatch) begin
        count <= nxt;
      end else if (state == FAULT && clr_err) begin
        count <= '0;
      end
    end
  end

  // Reset and FAULT both drive K=1 on every flop so the bank lands on 0
  assign force_clr = rst | (state == FAULT);

  always_comb begin
    j  = nxt & ~q_fb;
    k  = ~nxt & q_fb;
    tc = en & ~load & (up ? (q_fb == TOP) : (q_fb == '0));
    if (force_clr) begin
      j  = '0;
      k  = '1;
      tc = 1'b0;
    end
  end

  assign err = (state == FAULT);

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Bench for jk_counter_ctrl: JK flop bank in the loop, scoreboard queue
// fed by an arithmetic reference model, monitor compares every cycle.
module tb_jk_counter_ctrl;

  localparam int M = 10;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic       clr_err;
  logic [3:0] q_fb;
  logic [3:0] j;
  logic [3:0] k;
  logic       tc;
  logic       err;
  logic [3:0] count;
  logic [3:0] flip;
  logic [3:0] bank = 4'hd;

  typedef struct {
    logic [3:0] j;
    logic [3:0] k;
    logic       tc;
    logic       err;
    logic [3:0] count;
    logic [3:0] q;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int   m_bank;
  int   m_cnt;
  bit   m_fault;

  jk_counter_ctrl #(.WIDTH(4), .MODULUS(M)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .clr_err  (clr_err),
    .q_fb     (q_fb),
    .j        (j),
    .k        (k),
    .tc       (tc),
    .err      (err),
    .count    (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Four JK flops; flip injects single-event upsets into the bank
  always @(posedge clk) begin
    logic [3:0] b;
    for (int i = 0; i < 4; i++) begin
      case ({j[i], k[i]})
        2'b00: b[i] = bank[i];
        2'b01: b[i] = 1'b0;
        2'b10: b[i] = 1'b1;
        default: b[i] = ~bank[i];
      endcase
    end
    bank <= b ^ flip;
  end

  assign q_fb = bank;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        chk("q_fb", q_fb, x.q);
        chk("j", j, x.j);
        chk("k", k, x.k);
        chk("tc", tc, x.tc);
        chk("err", err, x.err);
        chk("count", count, x.count);
      end
    end
  end

  task automatic step(input bit r, input bit e, input bit u, input bit l,
                      input int lv, input bit c, input logic [3:0] f);
    exp_t x;
    int   nx;
    @(negedge clk);
    rst      = r;
    en       = e;
    up       = u;
    load     = l;
    load_val = 4'(lv);
    clr_err  = c;
    flip     = f;
    if (r || m_fault) begin
      nx   = 0;
      x.j  = 4'h0;
      x.k  = 4'hf;
      x.tc = 1'b0;
    end else begin
      if (l)           nx = (lv < M) ? lv : 0;
      else if (e && u) nx = (m_bank >= M - 1) ? 0 : m_bank + 1;
      else if (e)      nx = (m_bank == 0 || m_bank >= M) ? M - 1 : m_bank - 1;
      else             nx = m_bank;
      x.j  = 4'(nx) & ~4'(m_bank);
      x.k  = ~4'(nx) & 4'(m_bank);
      x.tc = e && !l && (u ? m_bank == M - 1 : m_bank == 0);
    end
    x.err   = m_fault;
    x.count = 4'(m_cnt);
    x.q     = 4'(m_bank);
    sb.push_back(x);
    if (r) begin
      m_cnt   = 0;
      m_fault = 0;
    end else if (m_fault) begin
      if (c) begin
        m_fault = 0;
        m_cnt   = 0;
      end
    end else if (m_bank != m_cnt) begin
      m_fault = 1;
    end else begin
      m_cnt = nx;
    end
    m_bank = int'(4'(nx) ^ f);
  endtask

  task automatic do_load(input int v);
    step(0, 0, 0, 1, v, 0, 4'h0);
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    up       = 1'b0;
    load     = 1'b0;
    load_val = 4'h0;
    clr_err  = 1'b0;
    flip     = 4'h0;
    @(posedge clk);
    m_bank  = 0;
    m_cnt   = 0;
    m_fault = 0;

    repeat (2) step(1, 0, 0, 0, 0, 0, 4'h0);
    repeat (12) step(0, 1, 1, 0, 0, 0, 4'h0);

    do_load(0);
    repeat (3) step(0, 1, 0, 0, 0, 0, 4'h0);

    do_load(4);
    step(0, 1, 1, 1, 7, 0, 4'h0);
    step(0, 1, 1, 1, 12, 0, 4'h0);

    do_load(6);
    repeat (5) step(0, 0, 1, 0, 0, 0, 4'h0);

    do_load(3);
    step(0, 0, 0, 0, 0, 0, 4'b0100);
    repeat (3) step(0, 1, 1, 0, 0, 0, 4'h0);
    step(0, 1, 1, 0, 0, 1, 4'h0);
    repeat (3) step(0, 1, 1, 0, 0, 0, 4'h0);

    do_load(5);
    step(1, 1, 1, 0, 0, 0, 4'h0);
    repeat (3) step(0, 1, 1, 0, 0, 0, 4'h0);

    step(0, 0, 0, 0, 0, 0, 4'(m_bank ^ 13));
    repeat (2) step(0, 1, 0, 0, 0, 0, 4'h0);
    step(0, 1, 0, 0, 0, 1, 4'h0);
    repeat (3) step(0, 1, 0, 0, 0, 0, 4'h0);

    for (int i = 0; i < 400; i++) begin
      bit         r;
      bit         e;
      bit         u;
      bit         l;
      bit         c;
      int         lv;
      logic [3:0] f;
      r  = ($urandom % 50) == 0;
      e  = ($urandom % 4) != 0;
      u  = $urandom % 2;
      l  = ($urandom % 6) == 0;
      c  = ($urandom % 4) == 0;
      lv = $urandom % 16;
      f  = (($urandom % 40) == 0) ? 4'(1 << ($urandom % 4)) : 4'h0;
      step(r, e, u, l, lv, c, f);
    end

    @(negedge clk);
    #3;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
